// File: rtl/slave_wr_burst_ctrl.sv
// Per-slave DDR write-request controller: turns source FIFO fill into arbiter bursts
// and walks the word offset of one frame buffer in {bank, slave id, offset} space.
module slave_wr_burst_ctrl #(
    parameter int unsigned     ID_W        = 4,
    parameter logic [ID_W-1:0] SLAVE_ID    = '0,
    parameter int unsigned     BANK_W      = 2,
    parameter int unsigned     OFF_W       = 19,
    parameter int unsigned     FRAME_WORDS = 245760,
    parameter int unsigned     BURST_LEN   = 256,
    parameter int unsigned     BLEN_W      = 10,
    localparam int unsigned    ADDR_W      = BANK_W + ID_W + OFF_W
) (
    input  logic              ddr_clk,
    input  logic              sys_rstn,
    input  logic              frame_start,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [BLEN_W-1:0] fifo_len,
    input  logic              fifo_full,
    output logic              slave_req,
    input  logic              arbitrate_valid,
    output logic [ADDR_W-1:0] slave_waddr,
    output logic [BLEN_W-1:0] slave_wburst_len,
    output logic              frame_finished,
    output logic              empty_error,
    output logic              overflow_error
);

    typedef enum logic [1:0] {StIdle, StReq, StBusy, StDone} state_e;

    localparam logic [OFF_W:0]   FRAME_X   = (OFF_W + 1)'(FRAME_WORDS);
    localparam logic [OFF_W:0]   BURST_X   = (OFF_W + 1)'(BURST_LEN);
    localparam logic [OFF_W-1:0] FRAME_OFF = OFF_W'(FRAME_WORDS);

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              pend_q, pend_d;
    logic              req_q, req_d;
    logic [BLEN_W-1:0] blen_q, blen_d;
    logic              done_q, done_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;

    logic [OFF_W:0]    remaining;
    logic [BLEN_W-1:0] need;
    logic [OFF_W-1:0]  offset_sum;
    logic              apply_restart;
    logic              partial_frame;

    // Extra MSB keeps remaining exact even when offset sits at FRAME_WORDS.
    assign remaining     = FRAME_X - {1'b0, offset_q};
    assign need          = (remaining < BURST_X) ? remaining[BLEN_W-1:0] : BLEN_W'(BURST_LEN);
    assign offset_sum    = offset_q + OFF_W'(blen_q);
    assign partial_frame = (offset_q != '0) && (offset_q != FRAME_OFF);

    always_comb begin
        state_d       = state_q;
        offset_d      = offset_q;
        bank_d        = bank_q;
        pend_d        = pend_q;
        req_d         = req_q;
        blen_d        = blen_q;
        done_d        = done_q;
        ovf_d         = ovf_q;
        empty_d       = 1'b0;
        apply_restart = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pend_q || frame_start) begin
                    apply_restart = 1'b1;
                end else if (!done_q && ((fifo_len >= need) || fifo_full)) begin
                    blen_d  = need;
                    req_d   = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (frame_start) pend_d = 1'b1;
                if (arbitrate_valid) begin
                    req_d   = 1'b0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (frame_start) pend_d = 1'b1;
                if (!arbitrate_valid) begin
                    offset_d = offset_sum;
                    if (offset_sum == FRAME_OFF) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDone: begin
                // A restart deferred from the last burst is honoured here as well.
                if (frame_start || pend_q) begin
                    apply_restart = 1'b1;
                    state_d       = StIdle;
                end
            end
        endcase

        if (apply_restart) begin
            offset_d = '0;
            bank_d   = wr_bank;
            done_d   = 1'b0;
            ovf_d    = 1'b0;
            pend_d   = 1'b0;
            empty_d  = partial_frame;
        end

        // Set wins over the restart clear.
        if (fifo_full && !done_q && ((state_q == StIdle) || (state_q == StDone))) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge ddr_clk) begin
        if (!sys_rstn) begin
            state_q  <= StIdle;
            offset_q <= '0;
            bank_q   <= '0;
            pend_q   <= 1'b0;
            req_q    <= 1'b0;
            blen_q   <= '0;
            done_q   <= 1'b0;
            empty_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            bank_q   <= bank_d;
            pend_q   <= pend_d;
            req_q    <= req_d;
            blen_q   <= blen_d;
            done_q   <= done_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    assign slave_req        = req_q;
    assign slave_waddr      = {bank_q, SLAVE_ID, offset_q};
    assign slave_wburst_len = blen_q;
    assign frame_finished   = done_q;
    assign empty_error      = empty_q;
    assign overflow_error   = ovf_q;

endmodule

// File: tb/tb_slave_wr_burst_ctrl.sv
// Directed-plus-random bench for slave_wr_burst_ctrl; the bench plays the FIFO and the
// arbiter and tracks frame offset/bank/overflow in a small behavioural model.
module tb_slave_wr_burst_ctrl;

    localparam int unsigned ID_W   = 4;
    localparam logic [3:0]  ID     = 4'd5;
    localparam int unsigned BANK_W = 2;
    localparam int unsigned OFF_W  = 19;
    localparam int unsigned FW     = 600;
    localparam int unsigned BL     = 256;
    localparam int unsigned BLEN_W = 10;
    localparam int unsigned ADDR_W = BANK_W + ID_W + OFF_W;

    logic              ddr_clk;
    logic              sys_rstn;
    logic              frame_start;
    logic [BANK_W-1:0] wr_bank;
    logic [BLEN_W-1:0] fifo_len;
    logic              fifo_full;
    logic              slave_req;
    logic              arbitrate_valid;
    logic [ADDR_W-1:0] slave_waddr;
    logic [BLEN_W-1:0] slave_wburst_len;
    logic              frame_finished;
    logic              empty_error;
    logic              overflow_error;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_off;
    logic [1:0]  m_bank;
    logic        m_ovf;

    slave_wr_burst_ctrl #(
        .ID_W       (ID_W),
        .SLAVE_ID   (ID),
        .BANK_W     (BANK_W),
        .OFF_W      (OFF_W),
        .FRAME_WORDS(FW),
        .BURST_LEN  (BL),
        .BLEN_W     (BLEN_W)
    ) dut (
        .ddr_clk         (ddr_clk),
        .sys_rstn        (sys_rstn),
        .frame_start     (frame_start),
        .wr_bank         (wr_bank),
        .fifo_len        (fifo_len),
        .fifo_full       (fifo_full),
        .slave_req       (slave_req),
        .arbitrate_valid (arbitrate_valid),
        .slave_waddr     (slave_waddr),
        .slave_wburst_len(slave_wburst_len),
        .frame_finished  (frame_finished),
        .empty_error     (empty_error),
        .overflow_error  (overflow_error)
    );

    initial ddr_clk = 1'b0;
    always #5 ddr_clk = ~ddr_clk;

    task automatic step();
        @(posedge ddr_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr();
        return 32'({m_bank, ID, OFF_W'(m_off)});
    endfunction

    function automatic int min_need();
        return ((FW - m_off) < BL) ? (FW - m_off) : BL;
    endfunction

    task automatic restart(input logic [1:0] nb);
        wr_bank     = nb;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("restart_empty", 32'(empty_error), 32'((m_off != 0) && (m_off != FW)));
        m_off  = 0;
        m_bank = nb;
        m_ovf  = 1'b0;
        check("restart_addr", 32'(slave_waddr), exp_addr());
        check("restart_ff", 32'(frame_finished), 32'(0));
        check("restart_ovf", 32'(overflow_error), 32'(0));
        check("restart_req", 32'(slave_req), 32'(0));
        step();
        check("empty_pulse_end", 32'(empty_error), 32'(0));
    endtask

    task automatic issue();
        int need;
        need = min_need();
        if (need > 1) begin
            fifo_len = 10'($urandom_range(0, need - 1));
            step();
            step();
            check("no_req_below_need", 32'(slave_req), 32'(0));
        end
        fifo_len = ($urandom_range(0, 1) == 1) ? 10'(need) : 10'($urandom_range(need, 1023));
        step();
        check("req_latency", 32'(slave_req), 32'(1));
        check("req_addr", 32'(slave_waddr), exp_addr());
        check("req_len", 32'(slave_wburst_len), 32'(need));
        fifo_len = '0;
    endtask

    task automatic serve(input bit fs_mid, input logic [1:0] nb);
        int need;
        int hold;
        need = min_need();
        repeat ($urandom_range(0, 3)) begin
            step();
            check("req_hold", 32'(slave_req), 32'(1));
            check("addr_hold", 32'(slave_waddr), exp_addr());
        end
        arbitrate_valid = 1'b1;
        step();
        check("req_drop", 32'(slave_req), 32'(0));
        hold = $urandom_range(1, 6);
        for (int i = 0; i < hold; i++) begin
            if (fs_mid && i == 0) begin
                wr_bank     = nb;
                frame_start = 1'b1;
            end
            step();
            frame_start = 1'b0;
            check("addr_busy", 32'(slave_waddr), exp_addr());
        end
        if (fs_mid) fifo_len = 10'd1023;
        arbitrate_valid = 1'b0;
        step();
        m_off += need;
        check("grant_fall_addr", 32'(slave_waddr), exp_addr());
        check("frame_finished", 32'(frame_finished), 32'(m_off == FW));
        check("ovf_track", 32'(overflow_error), 32'(m_ovf));
        check("req_after_fall", 32'(slave_req), 32'(0));
        if (fs_mid) begin
            step();
            check("mid_empty", 32'(empty_error), 32'((m_off != 0) && (m_off != FW)));
            m_off  = 0;
            m_bank = nb;
            m_ovf  = 1'b0;
            check("mid_restart_addr", 32'(slave_waddr), exp_addr());
            check("mid_no_req", 32'(slave_req), 32'(0));
            fifo_len = '0;
            step();
            check("mid_empty_end", 32'(empty_error), 32'(0));
            check("mid_no_req2", 32'(slave_req), 32'(0));
        end
    endtask

    task automatic run_frame();
        while (m_off < FW) begin
            issue();
            serve(1'b0, 2'b00);
        end
        fifo_len  = 10'd1023;
        fifo_full = 1'b1;
        step();
        step();
        check("done_no_req", 32'(slave_req), 32'(0));
        check("done_no_ovf", 32'(overflow_error), 32'(0));
        check("done_ff", 32'(frame_finished), 32'(1));
        fifo_full = 1'b0;
        fifo_len  = '0;
        step();
    endtask

    initial begin
        sys_rstn        = 1'b0;
        frame_start     = 1'b0;
        wr_bank         = '0;
        fifo_len        = '0;
        fifo_full       = 1'b0;
        arbitrate_valid = 1'b0;
        m_off           = 0;
        m_bank          = 2'b00;
        m_ovf           = 1'b0;
        repeat (3) step();
        check("rst_req", 32'(slave_req), 32'(0));
        check("rst_addr", 32'(slave_waddr), exp_addr());
        check("rst_len", 32'(slave_wburst_len), 32'(0));
        check("rst_ff", 32'(frame_finished), 32'(0));
        check("rst_empty", 32'(empty_error), 32'(0));
        check("rst_ovf", 32'(overflow_error), 32'(0));
        sys_rstn = 1'b1;
        step();
        check("idle_no_req", 32'(slave_req), 32'(0));

        // Random full frames, including exact-need final short bursts
        for (int f = 0; f < 3; f++) begin
            restart(2'($urandom_range(0, 3)));
            run_frame();
        end

        // Restart in IDLE after a partial frame
        restart(2'b01);
        issue();
        serve(1'b0, 2'b00);
        restart(2'b10);
        check("t3_addr", 32'(slave_waddr), 32'({2'b10, ID, 19'd0}));

        // Restart requested during BUSY is deferred past the grant fall
        issue();
        serve(1'b0, 2'b00);
        issue();
        serve(1'b1, 2'b11);

        // fifo_full below need forces a full-length request and flags overflow
        fifo_len  = 10'd100;
        fifo_full = 1'b1;
        step();
        fifo_full = 1'b0;
        fifo_len  = '0;
        m_ovf     = 1'b1;
        check("ovf_req", 32'(slave_req), 32'(1));
        check("ovf_len", 32'(slave_wburst_len), 32'(256));
        check("ovf_set", 32'(overflow_error), 32'(1));
        check("ovf_addr", 32'(slave_waddr), exp_addr());
        serve(1'b0, 2'b00);
        restart(2'b01);

        // Reset in the middle of a burst
        issue();
        arbitrate_valid = 1'b1;
        step();
        check("busy_req_low", 32'(slave_req), 32'(0));
        sys_rstn = 1'b0;
        step();
        sys_rstn = 1'b1;
        m_off    = 0;
        m_bank   = 2'b00;
        m_ovf    = 1'b0;
        check("mrst_req", 32'(slave_req), 32'(0));
        check("mrst_addr", 32'(slave_waddr), exp_addr());
        check("mrst_len", 32'(slave_wburst_len), 32'(0));
        check("mrst_ff", 32'(frame_finished), 32'(0));
        check("mrst_ovf", 32'(overflow_error), 32'(0));
        arbitrate_valid = 1'b0;
        step();
        step();
        check("mrst_no_update", 32'(slave_waddr), exp_addr());
        check("mrst_no_req", 32'(slave_req), 32'(0));
        run_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
